// File: rtl/ulaplus_palette_arb_pkg.sv
// Shared types for the ULAplus palette arbiter: palette geometry and the CPU write payload.
package ulaplus_palette_arb_pkg;

   localparam int unsigned PAL_AW = 6;
   localparam int unsigned PAL_DW = 8;

   typedef logic [PAL_DW-1:0] pal_entry_t;

   typedef struct packed {
      logic [PAL_AW-1:0] addr;
      pal_entry_t        data;
   } pal_wr_t;

endpackage

// File: rtl/ulaplus_palette_arb_wfifo.sv
// ulaplus_wfifo: synchronous FIFO of buffered CPU palette writes (pal_wr_t), flush has priority.
module ulaplus_wfifo
   import ulaplus_palette_arb_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic          clk28,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  pal_wr_t       din,
   output pal_wr_t       dout,
   output logic          full,
   output logic          empty,
   output logic [AW:0]   count
);

   pal_wr_t        mem_q [DEPTH];
   logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
   logic [AW:0]    cnt_q, cnt_d;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
         endcase
      end
   end

   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk28) begin
      if (push && !flush) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign full  = (cnt_q == (AW+1)'(DEPTH));
   assign empty = (cnt_q == '0);
   assign count = cnt_q;

endmodule

// File: rtl/ulaplus_palette_arb.sv
// ULAplus palette RAM arbiter: video > read-back > buffered CPU writes.
// Optional CPU read-back path enabled by defining ULAPLUS_READBACK_EN.
module ulaplus_palette_arb
   import ulaplus_palette_arb_pkg::*;
#(
   parameter int unsigned WFIFO_DEPTH = 4
) (
   input  logic              clk28,
   input  logic              rst_n,
   input  logic              en,
   input  logic              wr_req,
   input  logic [PAL_AW-1:0] wr_addr,
   input  logic [PAL_DW-1:0] wr_data,
   input  logic              rd_req,
   input  logic [PAL_AW-1:0] rd_addr,
   output logic [PAL_DW-1:0] rd_data,
   output logic              rd_valid,
   input  logic              vid_req,
   input  logic [PAL_AW-1:0] vid_addr,
   output logic [PAL_DW-1:0] vid_data,
   output logic              vid_valid,
   output logic [PAL_AW-1:0] ram_addr,
   output logic              ram_we,
   output logic [PAL_DW-1:0] ram_wdata,
   input  logic [PAL_DW-1:0] ram_rdata,
   output logic              wfifo_full,
   output logic              overflow
);

   localparam int unsigned CW = $clog2(WFIFO_DEPTH) + 1;

   pal_wr_t           fifo_din;
   pal_wr_t           fifo_head;
   logic              fifo_full, fifo_empty;
   logic [CW-1:0]     wfifo_cnt_unused;
   logic              push_c, pop_c, drop_c, grant_rd_c;
   logic [PAL_AW-1:0] rd_sel_addr_c;

   logic [PAL_AW-1:0] ram_addr_q, ram_addr_d;
   logic              ram_we_q, ram_we_d;
   pal_entry_t        ram_wdata_q, ram_wdata_d;
   logic              vid_p1_q, vid_p1_d;
   logic              vid_valid_q, vid_valid_d;
   logic              overflow_q, overflow_d;

   // Disabling ULAplus stops new write grants; a write already on ram_* still lands.
   assign pop_c    = en && !vid_req && !fifo_empty;
   assign push_c   = wr_req && en && (!fifo_full || pop_c);
   assign drop_c   = wr_req && en && fifo_full && !pop_c;
   assign fifo_din = '{addr: wr_addr, data: wr_data};

   ulaplus_wfifo #(.DEPTH(WFIFO_DEPTH)) u_wfifo (
      .clk28 (clk28),
      .rst_n (rst_n),
      .flush (!en),
      .push  (push_c),
      .pop   (pop_c),
      .din   (fifo_din),
      .dout  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (wfifo_cnt_unused)
   );

   always_comb begin
      ram_addr_d  = ram_addr_q;
      ram_we_d    = 1'b0;
      ram_wdata_d = ram_wdata_q;
      vid_p1_d    = vid_req;
      vid_valid_d = vid_p1_q;
      overflow_d  = overflow_q;
      if (vid_req) begin
         ram_addr_d = vid_addr;
      end else if (grant_rd_c) begin
         ram_addr_d = rd_sel_addr_c;
      end else if (pop_c) begin
         ram_addr_d  = fifo_head.addr;
         ram_we_d    = 1'b1;
         ram_wdata_d = fifo_head.data;
      end
      if (!en)         overflow_d = 1'b0;
      else if (drop_c) overflow_d = 1'b1;
   end

   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         ram_addr_q  <= '0;
         ram_we_q    <= 1'b0;
         ram_wdata_q <= '0;
         vid_p1_q    <= 1'b0;
         vid_valid_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         ram_addr_q  <= ram_addr_d;
         ram_we_q    <= ram_we_d;
         ram_wdata_q <= ram_wdata_d;
         vid_p1_q    <= vid_p1_d;
         vid_valid_q <= vid_valid_d;
         overflow_q  <= overflow_d;
      end
   end

   // RAM output is forwarded in the cycle it becomes valid, keeping the 2-cycle lookup latency.
   assign vid_data   = vid_valid_q ? ram_rdata : '0;
   assign vid_valid  = vid_valid_q;
   assign ram_addr   = ram_addr_q;
   assign ram_we     = ram_we_q;
   assign ram_wdata  = ram_wdata_q;
   assign wfifo_full = fifo_full;
   assign overflow   = overflow_q;

`ifdef ULAPLUS_READBACK_EN
   logic              rd_pend_q, rd_pend_d;
   logic [PAL_AW-1:0] rd_addr_q, rd_addr_d;
   logic              rd_p1_q, rd_p1_d;
   logic              rd_valid_q, rd_valid_d;
   pal_entry_t        rd_hold_q, rd_hold_d;

   // Read waits for an empty FIFO so it observes every earlier CPU write.
   assign grant_rd_c    = en && rd_pend_q && fifo_empty && !vid_req;
   assign rd_sel_addr_c = rd_addr_q;

   always_comb begin
      rd_pend_d  = rd_pend_q;
      rd_addr_d  = rd_addr_q;
      rd_p1_d    = grant_rd_c;
      rd_valid_d = rd_p1_q;
      rd_hold_d  = rd_valid_q ? ram_rdata : rd_hold_q;
      if (grant_rd_c) rd_pend_d = 1'b0;
      if (rd_req && en) begin
         rd_pend_d = 1'b1;
         rd_addr_d = rd_addr;
      end
      if (!en) rd_pend_d = 1'b0;
   end

   always_ff @(posedge clk28) begin
      if (!rst_n) begin
         rd_pend_q  <= 1'b0;
         rd_addr_q  <= '0;
         rd_p1_q    <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_hold_q  <= '0;
      end else begin
         rd_pend_q  <= rd_pend_d;
         rd_addr_q  <= rd_addr_d;
         rd_p1_q    <= rd_p1_d;
         rd_valid_q <= rd_valid_d;
         rd_hold_q  <= rd_hold_d;
      end
   end

   assign rd_data  = rd_valid_q ? ram_rdata : rd_hold_q;
   assign rd_valid = rd_valid_q;
`else
   logic rd_unused;

   assign rd_unused     = ^{rd_req, rd_addr};
   assign grant_rd_c    = 1'b0;
   assign rd_sel_addr_c = '0;
   assign rd_data       = '0;
   assign rd_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_ulaplus_palette_arb.sv
// Directed bench for ulaplus_palette_arb with a synchronous 64x8 palette RAM model.
module tb_ulaplus_palette_arb;

   logic       clk28 = 1'b0;
   logic       rst_n, en;
   logic       wr_req, rd_req, vid_req;
   logic [5:0] wr_addr, rd_addr, vid_addr;
   logic [7:0] wr_data;
   logic [7:0] rd_data, vid_data, ram_wdata, ram_rdata;
   logic       rd_valid, vid_valid, ram_we, wfifo_full, overflow;
   logic [5:0] ram_addr;

   logic [7:0] ram_mem [64];
   logic       pre_we;
   logic [5:0] pre_addr;
   logic [7:0] pre_data;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk28 = ~clk28;

   ulaplus_palette_arb #(.WFIFO_DEPTH(4)) dut (
      .clk28(clk28), .rst_n(rst_n), .en(en),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
      .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .wfifo_full(wfifo_full), .overflow(overflow)
   );

   // Palette RAM: registered read, write-then-visible next access; preload port for setup.
   always @(posedge clk28) begin
      if (pre_we)      ram_mem[pre_addr] <= pre_data;
      else if (ram_we) ram_mem[ram_addr] <= ram_wdata;
      ram_rdata <= ram_mem[ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(negedge clk28);
   endtask

   initial begin
      int seen;
      rst_n = 1'b0; en = 1'b0;
      wr_req = 1'b0; wr_addr = '0; wr_data = '0;
      rd_req = 1'b0; rd_addr = '0;
      vid_req = 1'b1; vid_addr = 6'd5;
      pre_we = 1'b1; pre_addr = 6'd5; pre_data = 8'h1C;
      step(); step();
      pre_addr = 6'd9; pre_data = 8'h00;
      step();
      pre_we = 1'b0;
      step();

      // Reset values, with vid_req held high throughout
      chk("rst_ram_addr", 32'(ram_addr), 32'h0);
      chk("rst_ram_we", 32'(ram_we), 32'h0);
      chk("rst_ram_wdata", 32'(ram_wdata), 32'h0);
      chk("rst_vid_valid", 32'(vid_valid), 32'h0);
      chk("rst_vid_data", 32'(vid_data), 32'h0);
      chk("rst_rd_valid", 32'(rd_valid), 32'h0);
      chk("rst_rd_data", 32'(rd_data), 32'h0);
      chk("rst_overflow", 32'(overflow), 32'h0);
      chk("rst_full", 32'(wfifo_full), 32'h0);

      // 1: video lookup of RAM[5]=0x1C
      rst_n = 1'b1; en = 1'b1; vid_req = 1'b1; vid_addr = 6'd5;
      step();
      vid_req = 1'b0;
      chk("vid_ram_addr", 32'(ram_addr), 32'd5);
      chk("vid_valid_n1", 32'(vid_valid), 32'h0);
      step();
      chk("vid_valid_n2", 32'(vid_valid), 32'h1);
      chk("vid_data_n2", 32'(vid_data), 32'h1C);
      step();
      chk("vid_valid_n3", 32'(vid_valid), 32'h0);

      // 2: single CPU write with idle video
      wr_req = 1'b1; wr_addr = 6'd3; wr_data = 8'hE0;
      step();
      wr_req = 1'b0;
      chk("wr1_we_push", 32'(ram_we), 32'h0);
      step();
      chk("wr1_we", 32'(ram_we), 32'h1);
      chk("wr1_addr", 32'(ram_addr), 32'd3);
      chk("wr1_wdata", 32'(ram_wdata), 32'hE0);
      step();
      chk("wr1_we_off", 32'(ram_we), 32'h0);
      chk("wr1_addr_hold", 32'(ram_addr), 32'd3);

      // 3: video starves writes; 5th write overflows a depth-4 FIFO
      for (int c = 0; c < 5; c++) begin
         vid_req = 1'b1; vid_addr = 6'd0;
         wr_req = 1'b1; wr_addr = 6'(10 + c); wr_data = 8'(8'hA0 + c);
         step();
      end
      wr_req = 1'b0;
      chk("ovf_full", 32'(wfifo_full), 32'h1);
      chk("ovf_flag", 32'(overflow), 32'h1);
      chk("ovf_no_we", 32'(ram_we), 32'h0);
      for (int c = 0; c < 5; c++) step();
      vid_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk($sformatf("drain%0d_we", i), 32'(ram_we), 32'h1);
         chk($sformatf("drain%0d_addr", i), 32'(ram_addr), 32'(10 + i));
         chk($sformatf("drain%0d_wdata", i), 32'(ram_wdata), 32'(8'hA0 + i));
      end
      step();
      chk("drain_done_we", 32'(ram_we), 32'h0);
      chk("ovf_sticky", 32'(overflow), 32'h1);
      chk("drain_not_full", 32'(wfifo_full), 32'h0);

      // 4: full FIFO, pop and push in the same cycle
      en = 1'b0;
      step();
      en = 1'b1;
      chk("en_clr_ovf", 32'(overflow), 32'h0);
      for (int i = 0; i < 4; i++) begin
         vid_req = 1'b1; wr_req = 1'b1; wr_addr = 6'(30 + i); wr_data = 8'(8'h30 + i);
         step();
      end
      vid_req = 1'b0; wr_req = 1'b1; wr_addr = 6'd20; wr_data = 8'h77;
      step();
      wr_req = 1'b0;
      chk("pp_full", 32'(wfifo_full), 32'h1);
      chk("pp_ovf", 32'(overflow), 32'h0);
      chk("pp_we", 32'(ram_we), 32'h1);
      chk("pp_addr0", 32'(ram_addr), 32'd30);
      for (int i = 1; i < 4; i++) begin
         step();
         chk($sformatf("pp_addr%0d", i), 32'(ram_addr), 32'(30 + i));
      end
      step();
      chk("pp_last_addr", 32'(ram_addr), 32'd20);
      chk("pp_last_wdata", 32'(ram_wdata), 32'h77);
      step();
      chk("pp_done_we", 32'(ram_we), 32'h0);

      // 5: read-back after write
`ifdef ULAPLUS_READBACK_EN
      wr_req = 1'b1; wr_addr = 6'd9; wr_data = 8'h55;
      step();
      wr_req = 1'b0; rd_req = 1'b1; rd_addr = 6'd9;
      step();
      rd_req = 1'b0;
      chk("rb_write_first", 32'(ram_we), 32'h1);
      chk("rb_write_addr", 32'(ram_addr), 32'd9);
      chk("rb_valid_early", 32'(rd_valid), 32'h0);
      step();
      chk("rb_read_addr", 32'(ram_addr), 32'd9);
      chk("rb_read_we", 32'(ram_we), 32'h0);
      step();
      chk("rb_valid", 32'(rd_valid), 32'h1);
      chk("rb_data", 32'(rd_data), 32'h55);
      step();
      chk("rb_valid_off", 32'(rd_valid), 32'h0);
      chk("rb_data_hold", 32'(rd_data), 32'h55);
`else
      wr_req = 1'b1; wr_addr = 6'd9; wr_data = 8'h55;
      step();
      wr_req = 1'b0; rd_req = 1'b1; rd_addr = 6'd9;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         step();
         rd_req = 1'b0;
         if (rd_valid) seen++;
      end
      chk("rb_off_valid", 32'(seen), 32'h0);
      chk("rb_off_data", 32'(rd_data), 32'h0);
`endif

      // 6: en low flushes queued writes and clears overflow
      for (int i = 0; i < 5; i++) begin
         vid_req = 1'b1; wr_req = 1'b1; wr_addr = 6'(40 + i); wr_data = 8'(i);
         step();
      end
      wr_req = 1'b0;
      chk("fl_pre_ovf", 32'(overflow), 32'h1);
      chk("fl_pre_full", 32'(wfifo_full), 32'h1);
      en = 1'b0; vid_req = 1'b0;
      step();
      en = 1'b1;
      chk("fl_full", 32'(wfifo_full), 32'h0);
      chk("fl_ovf", 32'(overflow), 32'h0);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (ram_we) seen++;
         step();
      end
      chk("fl_no_we", 32'(seen), 32'h0);

      // Reset during an in-flight lookup discards the result
      vid_req = 1'b1; vid_addr = 6'd5;
      step();
      vid_req = 1'b0; rst_n = 1'b0;
      step();
      chk("rst_mid_valid", 32'(vid_valid), 32'h0);
      rst_n = 1'b1;
      step();
      chk("rst_mid_valid_after", 32'(vid_valid), 32'h0);
      chk("rst_mid_addr", 32'(ram_addr), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
